// File: rtl/rv32imf_apu_dispatcher_if.sv
// APU dispatch bus: core-side request/response signals plus the broadcast
// and per-channel signals towards NUM_CH FPU wrapper instances.
//   master : environment (core APU port + FPU channels)
//   slave  : rv32imf_apu_dispatcher
interface rv32imf_apu_dispatcher_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned NARGS    = 3,
  parameter int unsigned WOP      = 6,
  parameter int unsigned NDSFLAGS = 15,
  parameter int unsigned NUSFLAGS = 5
);
  // core side
  logic                             apu_req_i;
  logic                             apu_gnt_o;
  logic [NARGS-1:0][31:0]           apu_operands_i;
  logic [WOP-1:0]                   apu_op_i;
  logic [NDSFLAGS-1:0]              apu_flags_i;
  logic                             apu_rvalid_o;
  logic [31:0]                      apu_rdata_o;
  logic [NUSFLAGS-1:0]              apu_rflags_o;
  logic                             apu_busy_o;
  // channel side
  logic [NUM_CH-1:0]                ch_req_o;
  logic [NUM_CH-1:0]                ch_gnt_i;
  logic [NARGS-1:0][31:0]           ch_operands_o;
  logic [WOP-1:0]                   ch_op_o;
  logic [NDSFLAGS-1:0]              ch_flags_o;
  logic [NUM_CH-1:0]                ch_rvalid_i;
  logic [NUM_CH-1:0][31:0]          ch_rdata_i;
  logic [NUM_CH-1:0][NUSFLAGS-1:0]  ch_rflags_i;
  logic [NUM_CH-1:0]                ch_clk_en_o;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
           ch_gnt_i, ch_rvalid_i, ch_rdata_i, ch_rflags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_busy_o,
           ch_req_o, ch_operands_o, ch_op_o, ch_flags_o, ch_clk_en_o
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
           ch_gnt_i, ch_rvalid_i, ch_rdata_i, ch_rflags_i,
    output apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_busy_o,
           ch_req_o, ch_operands_o, ch_op_o, ch_flags_o, ch_clk_en_o
  );
endinterface

// File: rtl/rv32imf_apu_dispatcher.sv
// Round-robin dispatcher from the core APU port to NUM_CH FPU channels.
// Requests are issued to channel rr_ptr; results are returned to the core
// in issue order, with early completions held in per-channel result FIFOs.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : core request/grant, registered result strobe/data/flags,
//                   busy; per-channel req/gnt, broadcast operands/op/flags,
//                   per-channel result strobe/data/flags, clock enables
module rv32imf_apu_dispatcher #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned NARGS           = 3,
  parameter int unsigned WOP             = 6,
  parameter int unsigned NDSFLAGS        = 15,
  parameter int unsigned NUSFLAGS        = 5
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  rv32imf_apu_dispatcher_if.slave bus
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DW = 32 + NUSFLAGS;

  logic [PW-1:0]       rr_ptr;
  logic [CW-1:0]       count;
  logic [PW-1:0]       ord_mem [MAX_OUTSTANDING];
  logic [AW-1:0]       ord_rd;
  logic [AW-1:0]       ord_wr;
  logic [DW-1:0]       res_mem [NUM_CH][MAX_OUTSTANDING];
  logic [AW-1:0]       res_rd  [NUM_CH];
  logic [AW-1:0]       res_wr  [NUM_CH];
  logic [CW-1:0]       res_cnt [NUM_CH];
  logic [CW-1:0]       inflight[NUM_CH];
  logic                issued_since_rst;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic [NUSFLAGS-1:0] rflags_q;

  logic                room;
  logic                grant;
  logic                ord_empty;
  logic                retire;
  logic [PW-1:0]       head_ch;
  logic [PW-1:0]       rr_next;
  logic [DW-1:0]       head_entry;
  logic [NUM_CH-1:0]   ch_req;
  logic [NUM_CH-1:0]   res_push;
  logic [NUM_CH-1:0]   res_pop;
  logic [NUM_CH-1:0]   ch_issue;
  logic [NUM_CH-1:0]   ch_done;
  logic [NUM_CH-1:0]   ch_clk_en;

  always_comb begin
    room      = count < CW'(MAX_OUTSTANDING);
    ch_req    = '0;
    ch_req[rr_ptr] = bus.apu_req_i & room;
    grant     = room & bus.apu_req_i & bus.ch_gnt_i[rr_ptr];
    ord_empty = (count == '0);
    head_ch   = ord_mem[ord_rd];
    // Order FIFO occupancy equals count, so count doubles as its fill level.
    retire    = !ord_empty && (res_cnt[head_ch] != '0);
    head_entry = res_mem[head_ch][res_rd[head_ch]];
    rr_next   = (rr_ptr == PW'(NUM_CH - 1)) ? '0 : rr_ptr + PW'(1);
    res_push  = '0;
    res_pop   = '0;
    ch_issue  = '0;
    ch_done   = '0;
    ch_clk_en = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      // Results with no op in the order FIFO (protocol error or stale
      // results from before a reset) are dropped.
      res_push[k]  = bus.ch_rvalid_i[k] & !ord_empty;
      res_pop[k]   = retire && (head_ch == PW'(k));
      ch_issue[k]  = grant && (rr_ptr == PW'(k));
      ch_done[k]   = bus.ch_rvalid_i[k] && (inflight[k] != '0);
      ch_clk_en[k] = ch_req[k] | (inflight[k] != '0);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (grant) ord_mem[ord_wr] <= rr_ptr;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (res_push[k]) res_mem[k][res_wr[k]] <= {bus.ch_rdata_i[k], bus.ch_rflags_i[k]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr           <= '0;
      count            <= '0;
      ord_rd           <= '0;
      ord_wr           <= '0;
      issued_since_rst <= 1'b0;
      rvalid_q         <= 1'b0;
      rdata_q          <= '0;
      rflags_q         <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        res_rd[k]   <= '0;
        res_wr[k]   <= '0;
        res_cnt[k]  <= '0;
        inflight[k] <= '0;
      end
    end else begin
      if (grant) begin
        ord_wr           <= ord_wr + AW'(1);
        rr_ptr           <= rr_next;
        issued_since_rst <= 1'b1;
      end
      if (retire) ord_rd <= ord_rd + AW'(1);
      case ({grant, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      rvalid_q <= retire;
      rflags_q <= '0;
      if (retire) begin
        rdata_q  <= head_entry[DW-1:NUSFLAGS];
        rflags_q <= head_entry[NUSFLAGS-1:0];
      end

      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (res_push[k]) res_wr[k] <= res_wr[k] + AW'(1);
        if (res_pop[k])  res_rd[k] <= res_rd[k] + AW'(1);
        case ({res_push[k], res_pop[k]})
          2'b10:   res_cnt[k] <= res_cnt[k] + CW'(1);
          2'b01:   res_cnt[k] <= res_cnt[k] - CW'(1);
          default: ;
        endcase
        case ({ch_issue[k], ch_done[k]})
          2'b10:   inflight[k] <= inflight[k] + CW'(1);
          2'b01:   inflight[k] <= inflight[k] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  assign bus.apu_gnt_o     = grant;
  assign bus.apu_rvalid_o  = rvalid_q;
  assign bus.apu_rdata_o   = rdata_q;
  assign bus.apu_rflags_o  = rflags_q;
  assign bus.apu_busy_o    = (count != '0) | bus.apu_req_i;
  assign bus.ch_req_o      = ch_req;
  assign bus.ch_operands_o = bus.apu_operands_i;
  assign bus.ch_op_o       = bus.apu_op_i;
  assign bus.ch_flags_o    = bus.apu_flags_i;
  assign bus.ch_clk_en_o   = ch_clk_en;

  // Until the first issue after reset, channels may still deliver results
  // of ops launched before the reset; those are expected and silently dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chk
    a_res_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(res_push[k] && (res_cnt[k] == CW'(MAX_OUTSTANDING))));
    a_no_orphan_result : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.ch_rvalid_i[k] && ord_empty && issued_since_rst));
  end

endmodule

// File: doc/rv32imf_apu_dispatcher.md
Name: rv32imf_apu_dispatcher

Overview:
- Sits between the core's APU port and NUM_CH identical floating-point wrapper instances.
- Issues core APU requests round-robin across the channels, so several FP ops can be in flight at once.
- Returns results to the core strictly in issue order, buffering any results that complete early.
- Provides per-channel clock-enable outputs for the FPU clock gates.

Parameters:
- NUM_CH, 2, number of FPU channels (1..4)
- MAX_OUTSTANDING, 4, maximum in-flight ops across all channels; power of two, 2..8
- NARGS, 3, operand count per request
- WOP, 6, APU opcode width
- NDSFLAGS, 15, downstream flag width
- NUSFLAGS, 5, upstream result flag width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- apu_req_i  in  1  core request; held stable until granted
- apu_gnt_o  out  1  grant to core
- apu_operands_i  in  NARGS x 32  operands
- apu_op_i  in  WOP  opcode
- apu_flags_i  in  NDSFLAGS  flags to FPU
- apu_rvalid_o  out  1  one-cycle result strobe to core
- apu_rdata_o  out  32  result
- apu_rflags_o  out  NUSFLAGS  result flags
- apu_busy_o  out  1  at least one op is outstanding
- ch_req_o  out  NUM_CH  per-channel request
- ch_gnt_i  in  NUM_CH  per-channel grant
- ch_operands_o, ch_op_o, ch_flags_o  out  as core side  broadcast to all channels
- ch_rvalid_i  in  NUM_CH  per-channel result strobe
- ch_rdata_i  in  NUM_CH x 32  per-channel results
- ch_rflags_i  in  NUM_CH x NUSFLAGS  per-channel result flags
- ch_clk_en_o  out  NUM_CH  clock-enable for each channel's gate

Behaviour:
- Reset (async, rst_ni low):
  - all outputs 0
  - rr_ptr=0, count=0
  - order FIFO and all result buffers empty
- Clock and reset: single clock domain, clk_i, asynchronous active-low reset rst_ni.
- Issue (combinational):
  - room = (count < MAX_OUTSTANDING)
  - ch_req_o[rr_ptr] = apu_req_i & room; all other bits 0
  - apu_gnt_o = room & apu_req_i & ch_gnt_i[rr_ptr]
- On grant (registered):
  - push rr_ptr into the order FIFO (depth MAX_OUTSTANDING)
  - rr_ptr <= (rr_ptr+1) mod NUM_CH
  - count+1
- Pointer hold: rr_ptr never moves while a request is pending without grant, so the core's held request stays on one channel.
- Result capture:
  - each channel has a result FIFO, depth MAX_OUTSTANDING, holding {rdata, rflags}
  - ch_rvalid_i[k] pushes into FIFO k in the same edge
  - overflow is impossible by construction; an assertion flags push-when-full
- Retire:
  - when the order FIFO is non-empty and result FIFO[head] is non-empty: pop both
  - on the next edge drive apu_rvalid_o=1 with the popped data; count-1
  - at most one retire per cycle
- apu_rvalid_o/apu_rdata_o/apu_rflags_o are registered:
  - latency from ch_rvalid_i to apu_rvalid_o is 2 edges when the result is the oldest (capture edge, then retire edge)
  - a buffered result retires 1 edge after its predecessor
- apu_rdata_o holds its last value when rvalid is low; apu_rflags_o is forced to 0 when rvalid is low.
- Grant and retire in the same cycle: count unchanged, both FIFOs update correctly.
- count==MAX_OUTSTANDING: ch_req_o=0 and apu_gnt_o=0, even if channel grants are high.
- Empty order FIFO: a ch_rvalid_i arriving anyway is a protocol error; an assertion fires and the data is dropped.
- apu_busy_o = (count != 0) | apu_req_i.
- Clock enables:
  - ch_clk_en_o[k] = ch_req_o[k] | (ops outstanding on channel k > 0)
  - a per-channel in-flight counter, width clog2(MAX_OUTSTANDING+1), increments on issue to k and decrements on ch_rvalid_i[k]
- NUM_CH=1: degenerates to a pass-through with reorder buffering; rr_ptr is constant 0.
- Reset mid-operation clears everything; in-flight channel results arriving after reset are ignored by the same rule as the empty-FIFO case.

Test Plan:
- Single op, NUM_CH=2: req with ch_gnt_i=01, ch0 returns 0x3F800000 with flags 0 three cycles later -> apu_gnt_o=1 for one cycle; apu_rvalid_o=1 two edges after ch_rvalid_i[0], rdata=0x3F800000; count back to 0; rr_ptr=1.
- Out-of-order completion: op A to ch0 (latency 5), op B to ch1 (latency 1), B data 0xB, A data 0xA -> core sees 0xA then 0xB on consecutive cycles; never 0xB first.
- Back-pressure: 4 ops granted, 5th req held high with channel grants high -> apu_gnt_o stays 0 until the first retire; grant is asserted in the same cycle count drops to 3.
- Channel stall: ch1 holds gnt=0 for 6 cycles while rr_ptr=1 -> ch_req_o=10 throughout, rr_ptr unchanged, no spurious push.
- Simultaneous grant and retire at count=2 -> count stays 2; order FIFO contents are correct.
- Reset with 3 ops outstanding, then stale ch_rvalid_i pulses -> apu_rvalid_o stays 0, count=0, apu_busy_o=0, ch_clk_en_o=0.
